meanfilter_unwrap: RTL and testbench
====================================

// Module: meanfilter_unwrap
// PURPOSE
//  Stage directly downstream of the sliding mean filter. Takes the filter's scaled sum (value * 2^MEAN_Level)
//  and rescales it to DATA_WITH bits (round or truncate). Counts full-scale wrap crossings (top bits 11<->00)
//  into a signed turn counter. Emits a multi-turn absolute position with a one-cycle valid strobe.
// PARAMETERS
//  DATA_WITH   24  width of the single-turn position word (the filter's input width)
//  MEAN_Level  7   filter scaling shift; iData width = DATA_WITH+MEAN_Level; 0 allowed (no rescale)
//  TURN_W      8   width of the signed turn counter
// PORTS
//  clk        in   1                        system clock
//  rst_n      in   1                        synchronous reset, active low
//  en         in   1                        block enable
//  iReady     in   1                        filter ready level; a new sample is marked by its rising edge
//  iData      in   DATA_WITH+MEAN_Level     filter output (scaled sum)
//  oPos       out  TURN_W+DATA_WITH         {turns, single-turn position}
//  oTurns     out  TURN_W                   signed turn count (two's complement)
//  oValid     out  1                        one-cycle strobe, oPos/oTurns updated
//  oOverflow  out  1                        sticky: turn counter saturated
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): oPos=0, oTurns=0, oValid=0, oOverflow=0, FSM=IDLE, all pipe regs 0.
//    Reset has priority over every other event, including an in-flight sample.
//  - Strobe: strb = iReady & ~iReady_d. iReady_d is registered every cycle, regardless of en.
//  - Pipeline, all registered, fixed latency 3:
//    S0: edge cycle; capture iData when en=1.
//    S1: rescale. r = (d + RND) >> MEAN_Level, taken modulo 2^DATA_WITH.
//        RND = 2^(MEAN_Level-1) with rounding, else 0. MEAN_Level=0 -> r = d.
//        Carry out of DATA_WITH bits is discarded: full scale rounds to 0 (angle wrap).
//    S2: unwrap and turn update, then register outputs.
//    oValid goes high exactly 3 clk after the posedge that samples the edge.
//  - FSM:
//    IDLE: first rescaled sample is loaded as prev and output with turns unchanged. Go to TRACK.
//    TRACK: compare prev[top2] with r[top2].
//      11->00: turns+1.  00->11: turns-1.  Any other pair: no change.
//      Then prev <= r.
//  - Saturation: turns clamps at +2^(TURN_W-1)-1 and -2^(TURN_W-1). Hitting a clamp sets oOverflow.
//    oOverflow clears only on reset.
//  - en=0: new strobes are ignored; samples already in flight complete. FSM returns to IDLE.
//    oPos/oTurns hold their values, and turns is kept.
//    On the next sample after en returns high, no turn step is taken (IDLE reload).
//  - Back-to-back strobes: minimum 2 clk between edges. Each accepted strobe gives exactly one oValid.
//  - oPos = {oTurns, r}. Arithmetic is unsigned except turns.
// CONFIGURATION
//  MEANFILTER_ROUND_EN defined: rescale rounds half up (RND = 2^(MEAN_Level-1)).
//  Undefined: rescale truncates (RND = 0).
//  Latency, ports and all other behaviour are identical in both builds.
// TESTING
//  (DATA_WITH=24, MEAN_Level=7, TURN_W=8)
//  1 Basic: reset, en=1, iData=0x091A2B00, rise iReady
//    -> 3 clk later oValid=1 for 1 clk, oPos=0x00_123456, oTurns=0.
//  2 Rounding: iData=0x091A2B40
//    -> MEANFILTER_ROUND_EN: pos 0x123457. Without it: pos 0x123456.
//  3 Forward wrap: pos 0xFF0000 then iData=0x00800000 (pos 0x010000) -> oTurns=1, oPos=0x01_010000.
//    Reverse: 0x010000 -> 0xFF0000 -> oTurns back to 0.
//  4 Round-wrap (ROUND_EN): prev 0xFFFFFF, iData=0x7FFFFFC0 -> pos 0x000000, oTurns +1.
//  5 Saturation: 130 forward crossings -> oTurns=127 (0x7F), oOverflow=1.
//    Then one reverse crossing -> 126, oOverflow stays 1.
//  6 Reset mid-flight: rst_n=0 one cycle after a strobe -> no oValid, all outputs 0.
//    The next sample is treated as IDLE (oTurns=0).

Source files
------------

// File: rtl/meanfilter_unwrap_if.sv
`default_nettype none
// ============================================================================
// Module   : meanfilter_unwrap_if
// Brief    : Sample/position bundle between the mean filter and the unwrap stage.
// Revision : 1.0  initial release
// ============================================================================
interface meanfilter_unwrap_if #(
    parameter int DATA_WITH  = 24,
    parameter int MEAN_Level = 7,
    parameter int TURN_W     = 8
);
    logic                           en;
    logic                           iReady;
    logic [DATA_WITH+MEAN_Level-1:0] iData;
    logic [TURN_W+DATA_WITH-1:0]    oPos;
    logic [TURN_W-1:0]              oTurns;
    logic                           oValid;
    logic                           oOverflow;

    modport master (
        output en, iReady, iData,
        input  oPos, oTurns, oValid, oOverflow
    );

    modport slave (
        input  en, iReady, iData,
        output oPos, oTurns, oValid, oOverflow
    );
endinterface
`default_nettype wire

// File: rtl/meanfilter_unwrap.sv
`default_nettype none
// ============================================================================
// Module   : meanfilter_unwrap
// Brief    : Rescales the mean filter sum and unwraps it into a multi-turn
//            position. Build option MEANFILTER_ROUND_EN selects round-half-up.
// Revision : 1.0  initial release
// ============================================================================
module meanfilter_unwrap #(
    parameter int DATA_WITH  = 24,
    parameter int MEAN_Level = 7,
    parameter int TURN_W     = 8
) (
    input wire                 clk,
    input wire                 rst_n,
    meanfilter_unwrap_if.slave bus
);
    localparam int c_IN_W = DATA_WITH + MEAN_Level;
    localparam logic [TURN_W-1:0] c_TMAX = {1'b0, {(TURN_W-1){1'b1}}};
    localparam logic [TURN_W-1:0] c_TMIN = {1'b1, {(TURN_W-1){1'b0}}};
    localparam logic [TURN_W-1:0] c_ONE  = {{(TURN_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ready_d;
    logic                  w_strb;
    logic                  r_v0;
    logic [c_IN_W-1:0]     r_d0;
    logic                  r_v1;
    logic [DATA_WITH-1:0]  r_r1;
    logic [DATA_WITH-1:0]  w_rescaled;
    logic                  r_v2;
    logic [DATA_WITH-1:0]  r_r2;
    logic                  r_up;
    logic                  r_dn;
    logic [DATA_WITH-1:0]  r_prev;
    logic                  w_up;
    logic                  w_dn;
    logic                  r_valid;
    logic                  r_ovf;
    logic [DATA_WITH-1:0]  r_pos;
    logic [TURN_W-1:0]     r_turns;

    assign w_strb = bus.iReady & ~r_ready_d;

    // Sum is kept at input width so a carry out of the top bit is dropped (angle wrap).
    generate
        if (MEAN_Level == 0) begin : g_no_scale
            assign w_rescaled = r_d0;
        end else begin : g_scale
`ifdef MEANFILTER_ROUND_EN
            localparam logic [c_IN_W-1:0] c_RND = {{(c_IN_W-1){1'b0}}, 1'b1} << (MEAN_Level - 1);
`else
            localparam logic [c_IN_W-1:0] c_RND = '0;
`endif
            logic [c_IN_W-1:0] w_sum;
            assign w_sum      = r_d0 + c_RND;
            assign w_rescaled = DATA_WITH'(w_sum >> MEAN_Level);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_v1) w_state_nxt = S_TRACK;
            end
            S_TRACK: begin
                if (r_v1) begin
                    w_up = (r_prev[DATA_WITH-1 -: 2] == 2'b11) && (r_r1[DATA_WITH-1 -: 2] == 2'b00);
                    w_dn = (r_prev[DATA_WITH-1 -: 2] == 2'b00) && (r_r1[DATA_WITH-1 -: 2] == 2'b11);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Disabling forces a fresh reload on the next accepted sample.
        if (!bus.en) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_d <= 1'b0;
            r_v0      <= 1'b0;
            r_d0      <= '0;
            r_v1      <= 1'b0;
            r_r1      <= '0;
            r_v2      <= 1'b0;
            r_r2      <= '0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_prev    <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_pos     <= '0;
            r_turns   <= '0;
        end else begin
            r_ready_d <= bus.iReady;
            r_v0      <= w_strb & bus.en;
            if (w_strb && bus.en) r_d0 <= bus.iData;
            r_v1 <= r_v0;
            if (r_v0) r_r1 <= w_rescaled;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r2   <= r_r1;
                r_up   <= w_up;
                r_dn   <= w_dn;
                r_prev <= r_r1;
            end
            r_valid <= r_v2;
            if (r_v2) begin
                r_pos <= r_r2;
                if (r_up) begin
                    if (r_turns == c_TMAX) r_ovf   <= 1'b1;
                    else                   r_turns <= r_turns + c_ONE;
                end else if (r_dn) begin
                    if (r_turns == c_TMIN) r_ovf   <= 1'b1;
                    else                   r_turns <= r_turns - c_ONE;
                end
            end
        end
    end

    assign bus.oPos      = {r_turns, r_pos};
    assign bus.oTurns    = r_turns;
    assign bus.oValid    = r_valid;
    assign bus.oOverflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_meanfilter_unwrap.sv
`default_nettype none
// ============================================================================
// Module   : tb_meanfilter_unwrap
// Brief    : Self-checking bench for meanfilter_unwrap (both MEANFILTER_ROUND_EN builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_meanfilter_unwrap;
    localparam int DW = 24;
    localparam int ML = 7;
    localparam int TW = 8;
`ifdef MEANFILTER_ROUND_EN
    localparam longint RND = 64;
`else
    localparam longint RND = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference state: turns as a plain integer, previous position, reload flag.
    int     m_turns;
    bit     m_idle;
    bit     m_ovf;
    longint m_prev;
    longint m_exp_pos;

    meanfilter_unwrap_if #(.DATA_WITH(DW), .MEAN_Level(ML), .TURN_W(TW)) bus ();

    meanfilter_unwrap #(.DATA_WITH(DW), .MEAN_Level(ML), .TURN_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint rescale(input longint d);
        return ((d + RND) >> ML) & ((longint'(1) << DW) - 1);
    endfunction

    function automatic logic [30:0] at(input longint p);
        return 31'(p << ML);
    endfunction

    task automatic model_reset();
        m_turns   = 0;
        m_idle    = 1'b1;
        m_ovf     = 1'b0;
        m_prev    = 0;
        m_exp_pos = 0;
    endtask

    task automatic model_step(input longint d);
        longint p;
        longint pt;
        longint ct;
        p = rescale(d);
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            pt = m_prev >> (DW - 2);
            ct = p >> (DW - 2);
            if (pt == 3 && ct == 0) begin
                if (m_turns == 127) m_ovf = 1'b1;
                else                m_turns++;
            end else if (pt == 0 && ct == 3) begin
                if (m_turns == -128) m_ovf = 1'b1;
                else                 m_turns--;
            end
        end
        m_prev    = p;
        m_exp_pos = ((longint'(m_turns) & 255) << DW) | p;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_pos"},   64'(bus.oPos),      64'(m_exp_pos));
        check({tag, "_turns"}, 64'(bus.oTurns),    64'(m_turns & 255));
        check({tag, "_ovf"},   64'(bus.oOverflow), 64'(m_ovf));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.iReady = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("reset_valid", 64'(bus.oValid), 64'd0);
        check_outputs("reset");
    endtask

    // One iReady pulse; accept=0 means the strobe must be ignored.
    task automatic send(input logic [30:0] d, input bit accept);
        int nv;
        int lat;
        logic [31:0] pos_seen;
        logic [7:0]  turns_seen;
        nv = 0;
        lat = 0;
        pos_seen = 'x;
        turns_seen = 'x;
        if (accept) model_step(longint'(d));
        @(negedge clk);
        bus.iData  = d;
        bus.iReady = 1'b1;
        @(negedge clk);
        bus.iReady = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.oValid) begin
                nv++;
                lat = k;
                pos_seen = bus.oPos;
                turns_seen = bus.oTurns;
            end
        end
        if (accept) begin
            check("valid_count", 64'(nv), 64'd1);
            check("latency", 64'(lat), 64'd3);
            check("pos", 64'(pos_seen), 64'(m_exp_pos));
            check("turns", 64'(turns_seen), 64'(m_turns & 255));
            check("ovf", 64'(bus.oOverflow), 64'(m_ovf));
        end else begin
            check("ignored_count", 64'(nv), 64'd0);
            check_outputs("hold");
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b1;
        bus.iReady = 1'b0;
        bus.iData  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Basic and rounding samples
        send(31'h091A2B00, 1'b1);
        send(31'h091A2B40, 1'b1);

        // Forward then reverse wrap
        send(at(24'hFF0000), 1'b1);
        send(at(24'h010000), 1'b1);
        send(at(24'hFF0000), 1'b1);

        // Rounding carry at full scale
        send(at(24'hFFFFFF), 1'b1);
        send(31'h7FFFFFC0, 1'b1);

        // Disable: strobe ignored, next sample reloads without a turn step
        send(at(24'hC00000), 1'b1);
        bus.en = 1'b0;
        m_idle = 1'b1;
        send(at(24'h100000), 1'b0);
        bus.en = 1'b1;
        send(at(24'h000000), 1'b1);

        // Randomised samples with occasional disabled windows
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.en = 1'b0;
                m_idle = 1'b1;
                send(31'($urandom), 1'b0);
                bus.en = 1'b1;
            end
            send(31'($urandom), 1'b1);
        end

        // Saturation at the positive clamp, then one reverse crossing
        do_reset();
        send(at(24'hC00000), 1'b1);
        for (int i = 0; i < 130; i++) begin
            send(at(24'h000000), 1'b1);
            send(at(24'h400000), 1'b1);
            send(at(24'h800000), 1'b1);
            send(at(24'hC00000), 1'b1);
        end
        check("sat_turns", 64'(bus.oTurns), 64'h7F);
        check("sat_ovf", 64'(bus.oOverflow), 64'd1);
        send(at(24'h000000), 1'b1);
        send(at(24'hC00000), 1'b1);
        check("unsat_turns", 64'(bus.oTurns), 64'h7E);
        check("unsat_ovf", 64'(bus.oOverflow), 64'd1);

        // Reset one cycle after a strobe kills the in-flight sample
        begin
            int nv;
            nv = 0;
            @(negedge clk);
            bus.iData  = at(24'h123456);
            bus.iReady = 1'b1;
            @(negedge clk);
            bus.iReady = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (bus.oValid) nv++;
            end
            check("midflight_valid", 64'(nv), 64'd0);
            check_outputs("midflight");
        end
        send(at(24'hF00000), 1'b1);
        send(at(24'h000000), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
